// File: rtl/fifo_pop_stream.sv
// fifo_pop_stream: read-side adapter for a synchronous BRAM FIFO.
// Issues FIFO pops, absorbs the fixed read latency and presents the words
// as a valid/ready stream through a small skid buffer (RD_LAT+1 entries),
// which is just deep enough for one beat per cycle under backpressure.
// Optional feature: define FIFO_POP_STREAM_STATS_EN to build the
// accepted-beat counter; otherwise beat_count_o is tied to zero.
module fifo_pop_stream #(
  parameter  int DATA_WIDTH     = 36,
  parameter  int RD_LAT         = 1,
  parameter  int STARTUP_CYCLES = 16,
  localparam int BUF_DEPTH      = RD_LAT + 1,
  localparam int OCC_W          = $clog2(BUF_DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  fifo_empty_i,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  output logic                  fifo_pop_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [OCC_W-1:0]      occ_o,
  output logic [31:0]           beat_count_o
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = (STARTUP_CYCLES > 0) ? $clog2(STARTUP_CYCLES + 1) : 1;

  typedef enum logic {S_WAIT, S_RUN} state_t;

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        start_cnt;
  logic [RD_LAT-1:0]       infl;      // bit i set: pop issued i+1 cycles ago
  logic [DATA_WIDTH-1:0]   mem [BUF_DEPTH];
  logic [PTR_W-1:0]        rd_ptr, wr_ptr;
  logic [OCC_W-1:0]        occ;
  logic                    capture, xfer;
  int                      infl_cnt, level;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // State register; RUN is sticky until reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= S_WAIT;
    else       state <= state_nxt;
  end

  // Leave WAIT on the edge where the startup counter hits zero, so the first
  // pop lands exactly STARTUP_CYCLES cycles after reset.
  always_comb begin
    state_nxt = state;
    case (state)
      S_WAIT:  if (start_cnt <= CNT_W'(1)) state_nxt = S_RUN;
      S_RUN:   state_nxt = S_RUN;
      default: state_nxt = S_WAIT;
    endcase
  end

  // Startup settle counter, reloaded by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i)                              start_cnt <= CNT_W'(STARTUP_CYCLES);
    else if (state == S_WAIT && start_cnt != '0) start_cnt <= start_cnt - 1'b1;
  end

  // Pop credit: buffered + in-flight words after this cycle's dequeue must
  // leave room, so the buffer can never overflow.
  always_comb begin
    infl_cnt = 0;
    for (int i = 0; i < RD_LAT; i++) infl_cnt += int'(infl[i]);
    valid_o    = (occ != '0) && !flush_i;
    xfer       = valid_o && ready_i;
    level      = int'(occ) + infl_cnt - int'(xfer);
    capture    = infl[RD_LAT-1];
    fifo_pop_o = (state == S_RUN) && !fifo_empty_i && !flush_i && (level < BUF_DEPTH);
  end

  // Skid buffer and in-flight tracking; flush drops both, including the
  // word returning this cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      infl   <= '0;
      occ    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
    end else if (flush_i) begin
      infl   <= '0;
      occ    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      infl <= RD_LAT'({infl, fifo_pop_o});
      if (capture) begin
        mem[wr_ptr] <= fifo_data_i;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (xfer) rd_ptr <= ptr_inc(rd_ptr);
      occ <= occ + OCC_W'(capture) - OCC_W'(xfer);
    end
  end

  assign data_o = mem[rd_ptr];
  assign occ_o  = occ;

`ifdef FIFO_POP_STREAM_STATS_EN
  logic [31:0] beat_cnt;

  // Accepted-beat counter; survives flush, wraps naturally.
  always_ff @(posedge clk_i) begin
    if (rst_i)     beat_cnt <= '0;
    else if (xfer) beat_cnt <= beat_cnt + 32'd1;
  end

  assign beat_count_o = beat_cnt;
`else
  assign beat_count_o = 32'h0;
`endif

endmodule

// File: tb/tb_fifo_pop_stream.sv
// tb_fifo_pop_stream: scoreboard bench for fifo_pop_stream.
// A behavioural FIFO supplies words; every word popped and not later
// flushed/reset is queued as an expected beat, and a monitor compares beats
// in order. Directed phases cover startup, latency, backpressure, flush,
// stats and mid-stream reset, followed by randomized traffic.
module tb_fifo_pop_stream;

  localparam int DW = 36;
  localparam int BUF_DEPTH = 2;
`ifdef FIFO_POP_STREAM_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          ready = 1'b1;
  logic          fifo_empty;
  logic [DW-1:0] fifo_data = '0;
  logic          fifo_pop;
  logic          valid;
  logic [DW-1:0] data;
  logic [1:0]    occ;
  logic [31:0]   beat_count;

  fifo_pop_stream dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .fifo_empty_i(fifo_empty), .fifo_data_i(fifo_data), .fifo_pop_o(fifo_pop),
    .valid_o(valid), .ready_i(ready), .data_o(data),
    .occ_o(occ), .beat_count_o(beat_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural source FIFO: bench pushes, DUT pops.
  logic [DW-1:0] fifo_mem [0:8191];
  int fifo_wr = 0;
  int fifo_rd = 0;
  int pop_total = 0;
  assign fifo_empty = (fifo_rd == fifo_wr);

  logic [DW-1:0] exp_q[$];

  task automatic push(input logic [DW-1:0] w);
    fifo_mem[fifo_wr] = w;
    fifo_wr = fifo_wr + 1;
  endtask

  // FIFO model with read latency 1 plus expected-beat bookkeeping.
  always @(posedge clk) begin
    if (fifo_pop) begin
      check("pop_when_nonempty", 64'(fifo_rd != fifo_wr), 1);
      fifo_data <= fifo_mem[fifo_rd];
      fifo_rd   <= fifo_rd + 1;
      pop_total <= pop_total + 1;
    end
    if (flush && !rst) check("no_pop_during_flush", 64'(fifo_pop), 0);
    if (rst || flush) exp_q.delete();
    else if (fifo_pop) exp_q.push_back(fifo_mem[fifo_rd]);
  end

  // Output monitor: ordering, stall stability, occupancy bound, stats.
  int n_beats = 0;
  int n_since_rst = 0;
  logic [DW-1:0] last_beat = '0;
  logic prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall  = 1'b0;
      n_since_rst = 0;
    end else begin
      check("occ_bound", 64'(occ <= 2'(BUF_DEPTH)), 1);
      if (flush) check("valid_low_in_flush", 64'(valid), 0);
      if (prev_stall && !flush) begin
        check("stall_valid_held", 64'(valid), 1);
        check("stall_data_held", 64'(data), 64'(prev_data));
      end
      check("beat_count", 64'(beat_count), STATS ? 64'(32'(n_since_rst)) : 64'h0);
      if (valid && ready) begin
        check("beat_expected", 64'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) check("beat_data", 64'(data), 64'(exp_q.pop_front()));
        n_beats++;
        n_since_rst++;
        last_beat = data;
      end
      prev_stall = valid && !ready;
      prev_data  = data;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    int bad, b0, p0;
    logic done;
    // Startup: reset one cycle, words available from cycle 0.
    tick();
    rst = 1'b0;
    push(36'h1); push(36'h2); push(36'h3);
    @(negedge clk);
    check("rst_pop", 64'(fifo_pop), 0);
    check("rst_valid", 64'(valid), 0);
    check("rst_occ", 64'(occ), 0);
    check("rst_data", 64'(data), 0);
    check("rst_beat_count", 64'(beat_count), 0);
    bad = 0;
    for (int c = 1; c < 16; c++) begin
      @(negedge clk);
      if (fifo_pop) bad++;
    end
    check("startup_quiet", 64'(bad), 0);
    @(negedge clk);  // cycle 16
    check("first_pop_c16", 64'(fifo_pop), 1);
    @(negedge clk);  // cycle 17
    check("pop_c17", 64'(fifo_pop), 1);
    check("valid_c17", 64'(valid), 0);
    @(negedge clk);  // cycle 18
    check("pop_c18", 64'(fifo_pop), 1);
    check("valid_c18", 64'(valid), 1);
    check("data_c18", 64'(data), 64'h1);
    @(negedge clk);
    check("data_c19", 64'(data), 64'h2);
    @(negedge clk);
    check("data_c20", 64'(data), 64'h3);
    @(negedge clk);
    check("valid_c21", 64'(valid), 0);

    // Backpressure: only two pops, head held, then gap-free drain.
    tick();
    ready = 1'b0;
    p0 = pop_total;
    for (int k = 1; k <= 8; k++) push(DW'(k));
    repeat (6) tick();
    check("bp_pops", 64'(pop_total - p0), 2);
    check("bp_occ", 64'(occ), 2);
    check("bp_valid", 64'(valid), 1);
    check("bp_head", 64'(data), 64'h1);
    ready = 1'b1;
    b0 = n_beats;
    repeat (8) tick();
    check("bp_drain_beats", 64'(n_beats - b0), 8);
    @(negedge clk);
    check("bp_drain_empty", 64'(valid), 0);

    // Flush the cycle after a pop.
    tick();
    push(36'h55);
    @(negedge clk);
    check("flush_pre_pop", 64'(fifo_pop), 1);
    tick();
    flush = 1'b1;
    @(negedge clk);
    check("flush_valid", 64'(valid), 0);
    tick();
    flush = 1'b0;
    @(negedge clk);
    check("post_flush_valid", 64'(valid), 0);
    check("post_flush_occ", 64'(occ), 0);
    tick();
    push(36'hA);
    b0 = n_beats;
    for (int i = 0; i < 10 && n_beats == b0; i++) tick();
    check("post_flush_beat_seen", 64'(n_beats > b0), 1);
    check("post_flush_first", 64'(last_beat), 64'hA);

    // Stats: fresh reset, 5 beats, then a flush must not clear the count.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (17) tick();
    b0 = n_beats;
    for (int k = 0; k < 5; k++) push(DW'(36'h100 + k));
    for (int i = 0; i < 20 && n_beats - b0 < 5; i++) tick();
    check("stats_5_beats", 64'(beat_count), STATS ? 64'd5 : 64'd0);
    ready = 1'b0;
    push(36'h11); push(36'h12); push(36'h13);
    repeat (4) tick();
    check("pre_flush_occ", 64'(occ), 2);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clk);
    check("stats_after_flush", 64'(beat_count), STATS ? 64'd5 : 64'd0);
    check("flush_clears_occ", 64'(occ), 0);

    // Mid-stream reset with a full buffer.
    tick();
    push(36'h14); push(36'h15);
    repeat (5) tick();
    check("pre_rst_occ", 64'(occ), 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_valid", 64'(valid), 0);
    check("midrst_occ", 64'(occ), 0);
    check("midrst_data", 64'(data), 0);
    check("midrst_beat_count", 64'(beat_count), 0);
    bad = 0;
    if (fifo_pop) bad++;
    for (int c = 1; c < 16; c++) begin
      @(negedge clk);
      if (fifo_pop) bad++;
    end
    check("midrst_wait_quiet", 64'(bad), 0);
    @(negedge clk);
    check("midrst_first_pop", 64'(fifo_pop), 1);

    // Randomized traffic.
    tick();
    ready = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      tick();
      ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 9) < 6) push({4'($urandom), 32'($urandom)});
    end
    tick();
    flush = 1'b0;
    ready = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 500 && !done; i++) begin
      tick();
      done = (exp_q.size() == 0) && (fifo_rd == fifo_wr) && !valid;
    end
    check("drain_complete", 64'(done), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
